instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the decode stage inside cpu_top.
- Generates the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready interface.
- Accepts branch/jump redirects from execute and squashes all in-flight and buffered fetches.

Parameters:
- DATA_WIDTH, 32, instruction/address width; only 32 is supported.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2; also the outstanding-request limit.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_redirect_valid  in  1  redirect request from execute.
- i_redirect_pc  in  DATA_WIDTH  redirect target.
- o_imem_req  out  1  memory read request.
- o_imem_addr  out  DATA_WIDTH  request address; bits [1:0] always 0.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  read data valid.
- i_imem_rdata  in  DATA_WIDTH  read data.
- o_if_valid  out  1  instruction available to decode.
- o_if_instr  out  DATA_WIDTH  instruction word.
- o_if_pc  out  DATA_WIDTH  PC of o_if_instr.
- i_id_ready  in  1  decode accepts.

Interface (already decided): one clock, i_clk; reset i_reset is asynchronous and active-high.

Behaviour:
- Reset (async assert, sampled deassert):
  - pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=BOOT.
  - Outputs: o_imem_req=0, o_imem_addr=RESET_PC, o_if_valid=0, o_if_instr=0, o_if_pc=0.
- FSM states:
  - BOOT: one cycle after reset release, no request; then goes to FETCH.
  - FETCH: o_imem_req=1 while (fifo_count + outstanding) < FIFO_DEPTH; otherwise goes to FULL.
  - FULL: o_imem_req=0; returns to FETCH on the first cycle a credit frees.
  - Any state: i_redirect_valid forces FETCH next cycle.
- Request handshake:
  - Request completes on a cycle with req && gnt: pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0), outstanding++.
  - While req && !gnt, o_imem_addr and req are held stable. The only exceptions are a redirect or the credit check (credits cannot drop without a grant).
- Response:
  - rvalid arrives >= 1 cycle after its grant, responses in order.
  - On rvalid: outstanding--.
    - If discard > 0: discard--, data dropped.
    - Else: push {rdata, pc_of_request} into the FIFO. The request PC is tracked in a parallel PC queue or by recomputation.
  - The credit check guarantees no push when full. A push when full is a design error and is asserted in sim.
- Decode side:
  - o_if_valid = FIFO non-empty; instr/pc come from the FIFO head, registered.
  - Pop on o_if_valid && i_id_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty. An empty FIFO with a push shows o_if_valid the next cycle; there is no bypass, so latency grant->o_if_valid is >= 2 cycles.
- Redirect (i_redirect_valid=1):
  - Next cycle: pc = {i_redirect_pc[31:2],2'b00}, FIFO flushed, o_if_valid=0.
  - discard = outstanding after this cycle's grant/rvalid updates.
  - A request granted in the redirect cycle counts toward discard.
  - An rvalid in the redirect cycle is dropped.
  - A decode handshake in the redirect cycle completes normally; the CPU squashes it.
  - The new-target request is issued in the cycle after the redirect.
- Redirects on consecutive cycles: the last one wins, and discard accumulates correctly.
- Arithmetic: all counters are sized clog2(FIFO_DEPTH)+1 bits and never wrap.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined: adds outputs o_perf_fetched (32 bits) and o_perf_stall (32 bits), both reset to 0 and wrapping.
  - o_perf_fetched increments on each FIFO pop.
  - o_perf_stall increments each cycle where o_if_valid=0 and state != BOOT.
- Undefined: the ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset, gnt=1, rvalid 1 cycle after gnt, ready=1 -> addrs 0x0,0x4,0x8 on consecutive cycles; o_if_pc 0x0 first valid 3 cycles after reset release.
- Hold i_id_ready=0 -> at most FIFO_DEPTH=2 grants, then req=0; raise ready -> req resumes next cycle, no instruction lost or duplicated.
- gnt low for 5 cycles -> o_imem_addr and req stable throughout; grant accepted on cycle 6.
- Two outstanding requests, redirect to 0x103 -> next addr 0x100, both stale rvalids dropped, first o_if_pc=0x100.
- Redirect in the same cycle as gnt and rvalid -> the grant is discarded, the rvalid is dropped, and no stale instruction reaches decode.
- With IFU_PERF_CNT_EN: 10 pops and 4 empty cycles -> o_perf_fetched=10, o_perf_stall=4; i_reset mid-run -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, credit-limited imem requests, in-order instruction FIFO toward decode.
// Optional IFU_PERF_CNT_EN adds o_perf_fetched / o_perf_stall counters.
//   state    | meaning
//   ST_BOOT  | first cycle after reset release, no request
//   ST_FETCH | issuing requests while a credit is available
//   ST_FULL  | all credits used, waiting for a pop or dropped response
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_redirect_valid,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_if_valid,
  output logic [DATA_WIDTH-1:0] o_if_instr,
  output logic [DATA_WIDTH-1:0] o_if_pc,
  input  logic                  i_id_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           o_perf_fetched,
  output logic [31:0]           o_perf_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("instr_fetch_unit supports DATA_WIDTH=32 only");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_unit FIFO_DEPTH must be a power of two >= 2");
  end

  logic [1:0]            state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic [CNT_W-1:0]      outstanding, outstanding_nxt;
  logic [CNT_W-1:0]      discard, discard_nxt;
  logic [CNT_W-1:0]      fifo_count, fifo_count_nxt;
  logic [CNT_W-1:0]      credits_used;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rsp_pc;
  logic                  credit_ok, grant, rsp, push, pop;

  assign o_if_valid  = (fifo_count != '0);
  assign o_if_instr  = fifo_instr[rd_ptr];
  assign o_if_pc     = fifo_pc[rd_ptr];
  assign pop         = o_if_valid && i_id_ready;

  // A pop this cycle frees its slot before any new grant's data can return.
  assign credits_used = fifo_count + outstanding - CNT_W'(pop);
  assign credit_ok    = credits_used < DEPTH_C;

  assign o_imem_req  = (state == ST_FETCH) && credit_ok;
  assign o_imem_addr = pc;
  assign grant       = o_imem_req && i_imem_gnt;

  assign rsp  = i_imem_rvalid && (outstanding != '0);
  assign push = rsp && (discard == '0) && !i_redirect_valid;

  // With nothing to discard, the live requests are contiguous and end just below pc.
  assign rsp_pc = pc - (DATA_WIDTH'(outstanding) << 2);

  always_comb begin
    outstanding_nxt = outstanding;
    if (grant && !rsp) begin
      outstanding_nxt = outstanding + CNT_W'(1);
    end else if (!grant && rsp) begin
      outstanding_nxt = outstanding - CNT_W'(1);
    end
  end

  always_comb begin
    discard_nxt = discard;
    if (i_redirect_valid) begin
      discard_nxt = outstanding_nxt;
    end else if (rsp && discard != '0) begin
      discard_nxt = discard - CNT_W'(1);
    end
  end

  always_comb begin
    fifo_count_nxt = fifo_count;
    if (i_redirect_valid) begin
      fifo_count_nxt = '0;
    end else if (push && !pop) begin
      fifo_count_nxt = fifo_count + CNT_W'(1);
    end else if (pop && !push) begin
      fifo_count_nxt = fifo_count - CNT_W'(1);
    end
  end

  always_comb begin
    pc_nxt = pc;
    if (i_redirect_valid) begin
      pc_nxt = i_redirect_pc & ~DATA_WIDTH'(3);
    end else if (grant) begin
      pc_nxt = pc + DATA_WIDTH'(4);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:  state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = credit_ok ? ST_FETCH : ST_FULL;
      ST_FULL:  state_nxt = ((fifo_count_nxt + outstanding_nxt) < DEPTH_C) ? ST_FETCH : ST_FULL;
      default:  state_nxt = ST_BOOT;
    endcase
    if (i_redirect_valid) begin
      state_nxt = ST_FETCH;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      fifo_count  <= fifo_count_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (i_redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= i_imem_rdata;
        fifo_pc[wr_ptr]    <= rsp_pc;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  a_fifo_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(push && !pop && fifo_count == DEPTH_C));

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_perf_fetched <= '0;
      o_perf_stall   <= '0;
    end else begin
      if (pop) begin
        o_perf_fetched <= o_perf_fetched + 32'd1;
      end
      if (!o_if_valid && state != ST_BOOT) begin
        o_perf_stall <= o_perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
